// File: rtl/grf_hazard_scoreboard_pkg.sv
// Shared constants and types for the GRF Tnew/Tuse hazard scoreboard.
package grf_hazard_scoreboard_pkg;

    localparam logic [1:0] FWD_GRF   = 2'd0;
    localparam logic [1:0] FWD_EX    = 2'd1;
    localparam logic [1:0] FWD_MEM   = 2'd2;
    localparam logic [1:0] FWD_WB    = 2'd3;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_MAX  = 2'd2;

    typedef struct packed {
        logic       v;
        logic [4:0] wa;
    } hist_entry_t;

    // Tnew 3 has no producer class; it behaves like a load.
    function automatic logic [1:0] clamp_tnew(input logic [1:0] tnew);
        return (tnew > TNEW_MAX) ? TNEW_MAX : tnew;
    endfunction

endpackage

// File: rtl/hazard_operand_check.sv
// Per-operand hazard test and forwarding-source priority search (EX > MEM > WB).
module hazard_operand_check
    import grf_hazard_scoreboard_pkg::*;
(
    input  logic [4:0]  addr,
    input  logic [1:0]  tuse,
    input  logic [1:0]  cnt_val,
    input  hist_entry_t hist_ex,
    input  hist_entry_t hist_mem,
    input  hist_entry_t hist_wb,
    output logic        need,
    output logic [1:0]  fwd_sel
);

    assign need = (tuse != TUSE_NONE) && (addr != 5'd0) && (cnt_val > tuse);

    // Youngest matching writer wins, which keeps WAW sequences correct.
    always_comb begin
        fwd_sel = FWD_GRF;
        if (addr != 5'd0) begin
            if (hist_ex.v && (hist_ex.wa == addr)) begin
                fwd_sel = FWD_EX;
            end else if (hist_mem.v && (hist_mem.wa == addr)) begin
                fwd_sel = FWD_MEM;
            end else if (hist_wb.v && (hist_wb.wa == addr)) begin
                fwd_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/grf_hazard_scoreboard.sv
// Tnew/Tuse scoreboard for the GRF write port: ID stall and forwarding selects.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module grf_hazard_scoreboard
    import grf_hazard_scoreboard_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [1:0]  id_tuse_rs,
    input  logic [1:0]  id_tuse_rt,
    input  logic        id_we,
    input  logic [4:0]  id_wa,
    input  logic [1:0]  id_tnew,
    output logic        stall,
    output logic [1:0]  fwd_sel_rs,
    output logic [1:0]  fwd_sel_rt
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_count
`endif
);

    logic [1:0]  cnt [32];
    hist_entry_t hist_ex;
    hist_entry_t hist_mem;
    hist_entry_t hist_wb;
    logic        need_rs;
    logic        need_rt;
    logic        issue;

    hazard_operand_check u_check_rs (
        .addr     (id_rs),
        .tuse     (id_tuse_rs),
        .cnt_val  (cnt[id_rs]),
        .hist_ex  (hist_ex),
        .hist_mem (hist_mem),
        .hist_wb  (hist_wb),
        .need     (need_rs),
        .fwd_sel  (fwd_sel_rs)
    );

    hazard_operand_check u_check_rt (
        .addr     (id_rt),
        .tuse     (id_tuse_rt),
        .cnt_val  (cnt[id_rt]),
        .hist_ex  (hist_ex),
        .hist_mem (hist_mem),
        .hist_wb  (hist_wb),
        .need     (need_rt),
        .fwd_sel  (fwd_sel_rt)
    );

    assign stall = id_valid & (need_rs | need_rt);
    assign issue = id_valid & ~stall & id_we & (id_wa != 5'd0);

    // Entry 0 is never loaded (issue excludes $0), so it stays at 0 after reset.
    always_ff @(posedge clk) begin
        for (int r = 0; r < 32; r++) begin
            if (!reset) begin
                cnt[r] <= 2'd0;
            end else if (issue && (id_wa == 5'(r))) begin
                cnt[r] <= clamp_tnew(id_tnew);
            end else if (cnt[r] != 2'd0) begin
                cnt[r] <= cnt[r] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_ex  <= '0;
            hist_mem <= '0;
            hist_wb  <= '0;
        end else begin
            hist_ex  <= '{v: issue, wa: id_wa};
            hist_mem <= hist_ex;
            hist_wb  <= hist_mem;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count <= 32'd0;
        end else if (stall) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_grf_hazard_scoreboard.sv
// Self-checking bench for grf_hazard_scoreboard: directed vector table plus
// randomized traffic against a per-register "last issue" reference model.
module tb_grf_hazard_scoreboard;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] trs;
        logic [1:0] trt;
        logic       we;
        logic [4:0] wa;
        logic [1:0] tnew;
        logic       e_stall;
        logic [1:0] e_rs;
        logic [1:0] e_rt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [1:0]  id_tuse_rs;
    logic [1:0]  id_tuse_rt;
    logic        id_we;
    logic [4:0]  id_wa;
    logic [1:0]  id_tnew;
    logic        stall;
    logic [1:0]  fwd_sel_rs;
    logic [1:0]  fwd_sel_rt;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: cycle index of each register's youngest issue and its Tnew.
    int          cyc;
    int          last_issue [32];
    int          tnew_m [32];
    logic [31:0] stall_cnt_m;

    vec_t        tbl [$];

    always #5 clk = ~clk;

    grf_hazard_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_tuse_rs  (id_tuse_rs),
        .id_tuse_rt  (id_tuse_rt),
        .id_we       (id_we),
        .id_wa       (id_wa),
        .id_tnew     (id_tnew),
        .stall       (stall),
        .fwd_sel_rs  (fwd_sel_rs),
        .fwd_sel_rt  (fwd_sel_rt)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    function automatic vec_t mk(logic rst, logic valid, logic [4:0] rs, logic [4:0] rt,
                                logic [1:0] trs, logic [1:0] trt, logic we, logic [4:0] wa,
                                logic [1:0] tnew, logic e_stall, logic [1:0] e_rs, logic [1:0] e_rt);
        vec_t v;
        v.rst = rst; v.valid = valid; v.rs = rs; v.rt = rt; v.trs = trs; v.trt = trt;
        v.we = we; v.wa = wa; v.tnew = tnew; v.e_stall = e_stall; v.e_rs = e_rs; v.e_rt = e_rt;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(1, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) begin
            last_issue[r] = -1000;
            tnew_m[r]     = 0;
        end
        stall_cnt_m = 32'd0;
    endfunction

    // Cycles left before register r's youngest producer becomes forwardable.
    function automatic int remaining(logic [4:0] r);
        int rem;
        if (r == 5'd0) return 0;
        rem = tnew_m[r] + last_issue[r] + 1 - cyc;
        return (rem > 0) ? rem : 0;
    endfunction

    // Age of the youngest issue to r: 1 = EX, 2 = MEM, 3 = WB, otherwise GRF.
    function automatic logic [1:0] fwd_model(logic [4:0] r);
        int d;
        if (r == 5'd0) return 2'd0;
        d = cyc - last_issue[r];
        return (d >= 1 && d <= 3) ? 2'(d) : 2'd0;
    endfunction

    function automatic logic model_stall(vec_t v);
        logic need_rs;
        logic need_rt;
        need_rs = (v.trs != 2'd3) && (v.rs != 5'd0) && (remaining(v.rs) > int'(v.trs));
        need_rt = (v.trt != 2'd3) && (v.rt != 5'd0) && (remaining(v.rt) > int'(v.trt));
        return v.valid && (need_rs || need_rt);
    endfunction

    function automatic void model_step(vec_t v);
        logic s;
        s = model_stall(v);
        if (!v.rst) begin
            model_reset();
        end else begin
            if (v.valid && !s && v.we && (v.wa != 5'd0)) begin
                last_issue[v.wa] = cyc;
                tnew_m[v.wa]     = (v.tnew == 2'd3) ? 2 : int'(v.tnew);
            end
            if (s) stall_cnt_m = stall_cnt_m + 32'd1;
        end
        cyc++;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset      = v.rst;
        id_valid   = v.valid;
        id_rs      = v.rs;
        id_rt      = v.rt;
        id_tuse_rs = v.trs;
        id_tuse_rt = v.trt;
        id_we      = v.we;
        id_wa      = v.wa;
        id_tnew    = v.tnew;
        #1;
    endtask

    task automatic checkOne(input string name, input string what, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s %s: got %0d expected %0d", name, what, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic e_stall,
                               input logic [1:0] e_rs, input logic [1:0] e_rt);
        checkOne(name, "stall", int'(stall), int'(e_stall));
        checkOne(name, "fwd_sel_rs", int'(fwd_sel_rs), int'(e_rs));
        checkOne(name, "fwd_sel_rt", int'(fwd_sel_rt), int'(e_rt));
`ifdef HAZARD_STATS_EN
        checkOne(name, "stall_count", int'(stall_count), int'(stall_cnt_m));
`endif
    endtask

    initial begin
        vec_t cur;
        logic prev_stall;

        // Load-use with ALU consumer: one stall, then MEM forward.
        tbl.push_back(idle());
        tbl.push_back(mk(1, 1, 29, 0, 1, 3, 1, 8, 2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 8, 0, 1, 1, 1, 10, 1, 1, 1, 0));
        tbl.push_back(mk(1, 1, 8, 0, 1, 1, 1, 10, 1, 0, 2, 0));
        repeat (3) tbl.push_back(idle());
        // Load-use with branch consumer: two stalls, then WB forward.
        tbl.push_back(mk(1, 1, 29, 0, 1, 3, 1, 9, 2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 1, 2, 0));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        repeat (3) tbl.push_back(idle());
        // ALU then store reading rt late: no stall, EX forward.
        tbl.push_back(mk(1, 1, 2, 3, 1, 1, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 4, 1, 1, 2, 0, 0, 0, 0, 0, 1));
        repeat (3) tbl.push_back(idle());
        // Load to $0 never creates a hazard.
        tbl.push_back(mk(1, 1, 29, 0, 1, 3, 1, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) tbl.push_back(idle());
        // WAW: youngest ALU writer in EX wins.
        tbl.push_back(mk(1, 1, 29, 0, 1, 3, 1, 5, 2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 6, 7, 1, 1, 1, 5, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 5, 0, 1, 3, 0, 0, 0, 0, 1, 0));
        repeat (3) tbl.push_back(idle());
        // Illegal Tnew 3 behaves as 2.
        tbl.push_back(mk(1, 1, 29, 0, 1, 3, 1, 12, 3, 0, 0, 0));
        tbl.push_back(mk(1, 1, 12, 0, 0, 3, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 12, 0, 0, 3, 0, 0, 0, 1, 2, 0));
        tbl.push_back(mk(1, 1, 12, 0, 0, 3, 0, 0, 0, 0, 3, 0));
        repeat (3) tbl.push_back(idle());
        // Read-and-write of the same register checks the prior counter.
        tbl.push_back(mk(1, 1, 29, 0, 1, 3, 1, 13, 2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 13, 0, 1, 3, 1, 13, 1, 1, 1, 0));
        tbl.push_back(mk(1, 1, 13, 0, 1, 3, 1, 13, 1, 0, 2, 0));
        tbl.push_back(mk(1, 1, 13, 0, 0, 3, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 13, 0, 0, 3, 0, 0, 0, 0, 2, 0));
        repeat (3) tbl.push_back(idle());
        // Reset asserted during the first stall cycle discards the hazard.
        tbl.push_back(mk(1, 1, 29, 0, 1, 3, 1, 9, 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 9, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(idle());

        applyStimulus(mk(0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        model_reset();
        cyc = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("tbl%0d", i), tbl[i].e_stall, tbl[i].e_rs, tbl[i].e_rt);
            model_step(tbl[i]);
        end

        // Random traffic; a stalled instruction is held in ID like the real pipeline.
        prev_stall = 1'b0;
        cur = idle();
        for (int i = 0; i < 600; i++) begin
            logic e_stall;
            if (!(prev_stall && cur.rst)) begin
                cur.valid = ($urandom_range(0, 4) != 0);
                cur.rs    = 5'($urandom_range(0, 7));
                cur.rt    = 5'($urandom_range(0, 7));
                cur.trs   = 2'($urandom_range(0, 3));
                cur.trt   = 2'($urandom_range(0, 3));
                cur.we    = ($urandom_range(0, 3) != 0);
                cur.wa    = 5'($urandom_range(0, 7));
                cur.tnew  = 2'($urandom_range(0, 3));
            end
            cur.rst = ($urandom_range(0, 63) != 0);
            applyStimulus(cur);
            e_stall = model_stall(cur);
            checkOutput($sformatf("rnd%0d", i), e_stall, fwd_model(cur.rs), fwd_model(cur.rt));
            prev_stall = e_stall;
            model_step(cur);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
